// File: rtl/conv_accumulator_if.sv
// Term/result bundle between the convolution iterator and conv_accumulator.
// The master drives the per-term inputs and observes the requantised output stream.
interface conv_accumulator_if #(
   parameter int ADDR_W = 16
) ();
   logic              en_ctrl;
   logic              mac_en;
   logic              win_last;
   logic signed [7:0] pix;
   logic signed [7:0] wgt;
   logic signed [7:0] bias;
   logic [7:0]        ch;
   logic [7:0]        row;
   logic [7:0]        col;
   logic              out_valid;
   logic signed [7:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              done;

   modport master (
      output en_ctrl, mac_en, win_last, pix, wgt, bias, ch, row, col,
      input  out_valid, out_data, out_addr, done
   );

   modport slave (
      input  en_ctrl, mac_en, win_last, pix, wgt, bias, ch, row, col,
      output out_valid, out_data, out_addr, done
   );
endinterface

// File: rtl/conv_accumulator.sv
// Per-window multiply-accumulate on a bias, requantised to a signed byte with its output address.
// Optional macro CONV_RELU_EN clamps negative results to zero before the byte clamp.
module conv_accumulator #(
   parameter int CONV_DIM_OUT = 32,
   parameter int CONV_OUT_CH  = 32,
   parameter int BIAS_SHIFT   = 0,
   parameter int OUT_SHIFT    = 9,
   parameter int ACC_W        = 32,
   parameter int ADDR_W       = 16
) (
   input logic               clk,
   input logic               reset,
   conv_accumulator_if.slave bus
);
   localparam int DATA_W = 8;
   localparam int COEF_W = 8;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int TOTAL  = CONV_OUT_CH * CONV_DIM_OUT * CONV_DIM_OUT;
   localparam int CNT_W  = $clog2(TOTAL + 1);

   localparam logic [CNT_W-1:0]         TOTAL_C = CNT_W'(TOTAL);
   localparam logic [ADDR_W-1:0]        DIM_A   = ADDR_W'(CONV_DIM_OUT);
   localparam logic [ADDR_W-1:0]        DIM2_A  = ADDR_W'(CONV_DIM_OUT * CONV_DIM_OUT);
   localparam logic signed [ACC_W-1:0]  R_MAX   = ACC_W'(127);
   localparam logic signed [ACC_W-1:0]  R_MIN   = ACC_W'(-128);
   localparam logic signed [DATA_W-1:0] OUT_MAX = 8'sh7F;
   localparam logic signed [DATA_W-1:0] OUT_MIN = 8'sh80;

   function automatic logic signed [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] s);
      logic signed [ACC_W-1:0] r;
      r = s >>> OUT_SHIFT;
`ifdef CONV_RELU_EN
      if (r[ACC_W-1]) r = '0;
`endif
      if (r > R_MAX)      return OUT_MAX;
      else if (r < R_MIN) return OUT_MIN;
      else                return r[DATA_W-1:0];
   endfunction

   logic signed [PROD_W-1:0] prod_p0;
   logic signed [ACC_W-1:0]  bias_p0;
   logic [7:0]               ch_p0, row_p0, col_p0;
   logic                     vld_p0, last_p0;

   logic signed [ACC_W-1:0]  acc_p1, result_p1;
   logic                     fresh_p1, last_p1;
   logic [7:0]               ch_p1, row_p1, col_p1;

   logic [CNT_W-1:0]         cnt;

   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  term, base, sum;
   logic [ADDR_W-1:0]        addr_p1;

   assign bias_ext = ACC_W'(bus.bias);

   // Stage P: product, bias and indices; a stall kills the control flags only
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
      end else if (bus.en_ctrl) begin
         vld_p0  <= bus.mac_en;
         last_p0 <= bus.win_last;
      end else begin
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.en_ctrl) begin
         prod_p0 <= bus.pix * bus.wgt;
         bias_p0 <= bias_ext <<< BIAS_SHIFT;
         ch_p0   <= bus.ch;
         row_p0  <= bus.row;
         col_p0  <= bus.col;
      end
   end

   // Stage A: the first valid term of a window lands on the bias instead of the stale acc
   assign term = vld_p0 ? ACC_W'(prod_p0) : '0;
   assign base = fresh_p1 ? bias_p0 : acc_p1;
   assign sum  = base + term;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_p1   <= '0;
         fresh_p1 <= 1'b1;
         last_p1  <= 1'b0;
      end else begin
         last_p1 <= last_p0;
         if (last_p0) begin
            fresh_p1 <= 1'b1;
         end else if (vld_p0) begin
            acc_p1   <= sum;
            fresh_p1 <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (last_p0) begin
         result_p1 <= sum;
         ch_p1     <= ch_p0;
         row_p1    <= row_p0;
         col_p1    <= col_p0;
      end
   end

   // Output stage: requantise, address and completion count
   assign addr_p1 = ADDR_W'(ch_p1) * DIM2_A + ADDR_W'(row_p1) * DIM_A + ADDR_W'(col_p1);

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_addr  <= '0;
         bus.done      <= 1'b0;
         cnt           <= '0;
      end else begin
         bus.out_valid <= last_p1;
         if (last_p1) begin
            bus.out_data <= requant(result_p1);
            bus.out_addr <= addr_p1;
            if (cnt != TOTAL_C) begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == TOTAL_C - CNT_W'(1)) bus.done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_conv_accumulator.sv
// Self-checking bench for conv_accumulator: directed scenarios plus randomized windows
// checked against a plain-arithmetic per-window reference.
module tb_conv_accumulator;
   localparam int DIM = 2;
   localparam int OCH = 1;
   localparam int BSH = 0;
   localparam int OSH = 0;
   localparam int AW  = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_accumulator_if #(.ADDR_W(AW)) bus ();

   conv_accumulator #(
      .CONV_DIM_OUT(DIM), .CONV_OUT_CH(OCH), .BIAS_SHIFT(BSH),
      .OUT_SHIFT(OSH), .ACC_W(32), .ADDR_W(AW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int data; int addr; bit done; int at; } obs_t;
   obs_t obs_q[$];

   always @(negedge clk)
      if (bus.out_valid === 1'b1)
         obs_q.push_back('{int'(bus.out_data), int'(bus.out_addr), bus.done, cyc});

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (time %0t, want < 5000000)", $time);
      $fatal(1);
   end

   // Reference: bias plus the products of the valid terms, shifted, optionally rectified, clamped
   function automatic int ref_out(input int b, input int s);
      int r;
      r = ((b <<< BSH) + s) >>> OSH;
`ifdef CONV_RELU_EN
      if (r < 0) r = 0;
`endif
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   function automatic int ref_addr(input int c, input int r, input int co);
      return (c * DIM * DIM + r * DIM + co) % (1 << AW);
   endfunction

   task automatic idle();
      bus.en_ctrl = 1'b1; bus.mac_en = 1'b0; bus.win_last = 1'b0;
      bus.pix = '0; bus.wgt = '0; bus.bias = '0;
      bus.ch = '0; bus.row = '0; bus.col = '0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic term(input bit en, input bit mv, input bit wl, input int px, input int wg,
                       input int b, input int c, input int r, input int co, output int at);
      bus.en_ctrl = en; bus.mac_en = mv; bus.win_last = wl;
      bus.pix = 8'(px); bus.wgt = 8'(wg); bus.bias = 8'(b);
      bus.ch = 8'(c); bus.row = 8'(r); bus.col = 8'(co);
      @(posedge clk); #1;
      at = cyc;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      idle();
      tick(n);
      reset = 1'b0;
      obs_q.delete();
   endtask

   task automatic wait_obs(input int n);
      int k;
      k = 0;
      while (obs_q.size() < n && k < 300) begin tick(1); k++; end
      tick(3);
   endtask

   task automatic test_reset();
      int at;
      obs_t o;
      reset = 1'b1; idle(); tick(2);
      checks += 4;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      if (bus.out_data !== 8'sd0) begin errors++; $display("FAIL reset_data: got %0d want 0", bus.out_data); end
      if (bus.out_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.out_addr); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      reset = 1'b0; obs_q.delete();
      term(1, 1, 1, 3, 3, 20, 0, 1, 1, at);
      idle(); wait_obs(1);
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL reset_pre_count: got %0d outputs want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (o.data != ref_out(20, 9)) begin errors++; $display("FAIL reset_pre_data: got %0d want %0d", o.data, ref_out(20, 9)); end
      end
      // partial window, then 3 cycles of reset
      term(1, 1, 0, 10, 10, 50, 0, 0, 0, at);
      term(1, 1, 0, 5, 5, 50, 0, 0, 0, at);
      reset = 1'b1; idle(); tick(3);
      checks += 4;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", bus.out_valid); end
      if (bus.out_data !== 8'sd0) begin errors++; $display("FAIL midreset_data: got %0d want 0", bus.out_data); end
      if (bus.out_addr !== '0) begin errors++; $display("FAIL midreset_addr: got %0d want 0", bus.out_addr); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", bus.done); end
      reset = 1'b0; obs_q.delete();
      term(1, 1, 1, 2, 3, 7, 0, 0, 0, at);
      idle(); wait_obs(1);
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL reset_post_count: got %0d outputs want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (o.data != ref_out(7, 6)) begin errors++; $display("FAIL reset_post_data: got %0d want %0d", o.data, ref_out(7, 6)); end
      end
   endtask

   task automatic test_basic();
      int a1, a2, a3;
      obs_t o;
      do_reset(2);
      term(1, 1, 0, 2, 3, 5, 0, 0, 1, a1);
      term(1, 1, 0, -1, 4, 5, 0, 0, 1, a2);
      term(1, 1, 1, 10, 1, 5, 0, 0, 1, a3);
      idle(); wait_obs(1);
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL basic_count: got %0d outputs want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks += 3;
         if (o.data != 17) begin errors++; $display("FAIL basic_data: got %0d want 17", o.data); end
         if (o.at - a3 != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", o.at - a3); end
         if (o.addr != 1) begin errors++; $display("FAIL basic_addr: got %0d want 1", o.addr); end
      end
   endtask

   task automatic test_saturation();
      int at;
      obs_t o;
      int exp_d[2];
      do_reset(2);
      term(1, 1, 1, 127, 127, 0, 0, 0, 0, at);
      term(1, 1, 1, -128, 127, 0, 0, 0, 1, at);
      idle(); wait_obs(2);
      exp_d[0] = ref_out(0, 127 * 127);
      exp_d[1] = ref_out(0, -128 * 127);
      checks++;
      if (obs_q.size() != 2) begin
         errors++; $display("FAIL sat_count: got %0d outputs want 2", obs_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            o = obs_q.pop_front();
            checks++;
            if (o.data != exp_d[i]) begin errors++; $display("FAIL sat_data%0d: got %0d want %0d", i, o.data, exp_d[i]); end
         end
      end
   endtask

   task automatic test_padding();
      int at;
      obs_t o;
      int exp_d[2];
      do_reset(2);
      term(1, 1, 1, 5, 5, 0, 0, 0, 0, at);
      term(1, 0, 1, 100, 100, -3, 0, 0, 1, at);
      idle(); wait_obs(2);
      exp_d[0] = ref_out(0, 25);
      exp_d[1] = ref_out(-3, 0);
      checks++;
      if (obs_q.size() != 2) begin
         errors++; $display("FAIL pad_count: got %0d outputs want 2", obs_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            o = obs_q.pop_front();
            checks++;
            if (o.data != exp_d[i]) begin errors++; $display("FAIL pad_data%0d: got %0d want %0d", i, o.data, exp_d[i]); end
         end
      end
   endtask

   task automatic test_stall();
      int a1, at;
      obs_t o;
      do_reset(2);
      term(1, 1, 0, 2, 3, 5, 0, 1, 0, a1);
      term(1, 1, 0, -1, 4, 5, 0, 1, 0, at);
      repeat (4) term(0, 1, 1, 99, 99, 100, 0, 1, 1, at);
      term(1, 1, 1, 10, 1, 5, 0, 1, 0, at);
      idle(); wait_obs(1);
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL stall_count: got %0d outputs want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks += 3;
         if (o.data != 17) begin errors++; $display("FAIL stall_data: got %0d want 17", o.data); end
         if (o.at - a1 != 8) begin errors++; $display("FAIL stall_latency: got %0d want 8", o.at - a1); end
         if (o.addr != 2) begin errors++; $display("FAIL stall_addr: got %0d want 2", o.addr); end
      end
   endtask

   task automatic test_address_done();
      int at;
      obs_t o;
      do_reset(2);
      for (int i = 0; i < 4; i++) term(1, 1, 1, 1, 1, 0, 0, i / 2, i % 2, at);
      idle(); wait_obs(4);
      checks++;
      if (obs_q.size() != 4) begin
         errors++; $display("FAIL addr_count: got %0d outputs want 4", obs_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            o = obs_q.pop_front();
            checks += 2;
            if (o.addr != i) begin errors++; $display("FAIL addr%0d: got %0d want %0d", i, o.addr, i); end
            if (o.done != (i == 3)) begin errors++; $display("FAIL done_at%0d: got %b want %b", i, o.done, i == 3); end
         end
      end
      tick(5);
      checks++;
      if (bus.done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b want 1", bus.done); end
      term(1, 1, 1, 2, 2, 1, 0, 1, 1, at);
      idle(); wait_obs(1);
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL post_done_count: got %0d outputs want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks += 2;
         if (o.done !== 1'b1) begin errors++; $display("FAIL post_done_flag: got %b want 1", o.done); end
         if (o.data != ref_out(1, 4)) begin errors++; $display("FAIL post_done_data: got %0d want %0d", o.data, ref_out(1, 4)); end
      end
   endtask

   task automatic test_back_to_back();
      localparam int NW = 40;
      int at, len, b, c, r, co, s, px, wg;
      bit mv;
      int exp_d[$];
      int exp_a[$];
      obs_t o;
      do_reset(2);
      for (int w = 0; w < NW; w++) begin
         len = $urandom_range(1, 5);
         b   = $urandom_range(0, 255) - 128;
         c   = $urandom_range(0, 3);
         r   = $urandom_range(0, 3);
         co  = $urandom_range(0, 3);
         s   = 0;
         for (int t = 0; t < len; t++) begin
            if ($urandom_range(0, 5) == 0)
               term(0, 1, 1, 77, 77, 77, 3, 3, 3, at);
            mv = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) begin
               px = $urandom_range(0, 255) - 128;
               wg = $urandom_range(0, 255) - 128;
            end else begin
               px = $urandom_range(0, 16) - 8;
               wg = $urandom_range(0, 16) - 8;
            end
            if (mv) s += px * wg;
            term(1, mv, t == len - 1, px, wg, b, c, r, co, at);
         end
         exp_d.push_back(ref_out(b, s));
         exp_a.push_back(ref_addr(c, r, co));
      end
      idle(); wait_obs(NW);
      checks++;
      if (obs_q.size() != NW) begin
         errors++; $display("FAIL rand_count: got %0d outputs want %0d", obs_q.size(), NW);
      end else begin
         for (int i = 0; i < NW; i++) begin
            o = obs_q.pop_front();
            checks += 3;
            if (o.data != exp_d[i]) begin errors++; $display("FAIL rand_data%0d: got %0d want %0d", i, o.data, exp_d[i]); end
            if (o.addr != exp_a[i]) begin errors++; $display("FAIL rand_addr%0d: got %0d want %0d", i, o.addr, exp_a[i]); end
            if (o.done != (i >= 3)) begin errors++; $display("FAIL rand_done%0d: got %b want %b", i, o.done, i >= 3); end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_basic();
      test_saturation();
      test_padding();
      test_stall();
      test_address_done();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
